dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 5, data memory word-address width (32 words).
REQ-002 Parameter DATA_W, default 32, data word width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 p0_req, p1_req  input  1 each  access request from port 0 (CPU load/store) / port 1 (debug/loader).
REQ-006 p0_we, p1_we  input  1 each  1 = write, 0 = read.
REQ-007 p0_addr, p1_addr  input  ADDR_W each  word address.
REQ-008 p0_wdata, p1_wdata  input  DATA_W each  write data.
REQ-009 p0_gnt, p1_gnt  output  1 each  one-cycle pulse; request accepted and issued to memory this cycle.
REQ-010 p0_rvalid, p1_rvalid  output  1 each  one-cycle pulse; rdata valid for this port's read.
REQ-011 rdata  output  DATA_W  read data shared by both ports, qualified by pX_rvalid.
REQ-012 mem_en  output  1  data memory enable.
REQ-013 mem_we  output  1  data memory write enable.
REQ-014 mem_addr  output  ADDR_W  data memory address.
REQ-015 mem_wdata  output  DATA_W  data memory write data.
REQ-016 mem_rdata  input  DATA_W  data memory read data, valid one cycle after a read is issued.
REQ-017 busy  output  1  high while state is RD_WAIT.

Function
REQ-018 The FSM SHALL have two states: IDLE and RD_WAIT.
REQ-019 In IDLE with at least one pX_req high, the block SHALL select one winner, assert mem_en and the winner's pX_gnt combinationally in that cycle, and drive mem_we/mem_addr/mem_wdata from the winner's inputs.
REQ-020 A granted write SHALL complete in the grant cycle; the FSM SHALL remain in IDLE, with no rvalid.
REQ-021 A granted read SHALL move the FSM to RD_WAIT and record the winner in a registered owner bit.
REQ-022 In RD_WAIT the block SHALL pass mem_rdata to rdata, pulse the owner's pX_rvalid for exactly one cycle, issue no memory access, assert no gnt, and return to IDLE.
REQ-023 Read latency SHALL be 2 cycles (grant cycle to rvalid cycle, inclusive of one RD_WAIT cycle); write latency SHALL be 1 cycle.
REQ-024 When only one port requests, that port SHALL win.
REQ-025 When both request simultaneously, the port indicated by a round-robin pointer SHALL win; the pointer SHALL then point to the other port.
REQ-026 The pointer SHALL update only on a grant, and a single-port grant SHALL also set the pointer to the other port.
REQ-027 Requesters SHALL hold req/we/addr/wdata stable until gnt; a req withdrawn before gnt SHALL be dropped without side effect.
REQ-028 When no grant occurs, mem_en and mem_we SHALL be 0; mem_addr/mem_wdata are don't-care.
REQ-029 rdata SHALL hold its last value outside rvalid cycles.
REQ-030 gnt and rvalid SHALL be mutually exclusive across ports and never high together on one port.

Reset
REQ-031 Reset SHALL force state IDLE, pointer = port 0, owner = 0, rdata = 0; all gnt/rvalid outputs, mem_en, mem_we, and busy SHALL be 0.
REQ-032 A reset asserted during RD_WAIT SHALL abort the read; no rvalid SHALL follow after reset release.

Structure
REQ-033 A shared package dmem_pkg SHALL hold ADDR_W/DATA_W defaults and the state encoding constants (IDLE=0, RD_WAIT=1).
REQ-034 A sub-module rr_arbiter2 (2-input round-robin winner select with pointer register) SHALL implement REQ-024..026; the FSM and datapath muxing stay in dmem_arbiter.

Verification
REQ-035 Reset release, p0 write addr 5 data 0xDEADBEEF -> p0_gnt plus mem_en=1, mem_we=1, mem_addr=5 that cycle; no rvalid.
REQ-036 p1 read addr 5 after REQ-035 -> p1_gnt cycle N, busy and p1_rvalid at N+1 with rdata=0xDEADBEEF, p0_rvalid=0.
REQ-037 p0 and p1 both read continuously from reset -> grants alternate p0,p1,p0,p1 every 2 cycles, each rvalid routed to the correct port.
REQ-038 Both request writes while FSM in RD_WAIT -> no gnt, mem_en=0 that cycle; grant issued in the next IDLE cycle.
REQ-039 rst pulsed in the RD_WAIT cycle of a p0 read -> no p0_rvalid at any time, outputs at reset values, pointer back to p0.
REQ-040 p1_req raised then withdrawn while p0 holds grant priority -> no p1_gnt, no memory write to p1_addr.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: default widths, FSM state
// encoding and port identifiers used by the round-robin pointer and owner bit.
package dmem_pkg;

  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_e;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin winner select. The pointer names the port that wins
// a tie and moves to the other port after every grant, including uncontested ones.
module rr_arbiter2
  import dmem_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic req0_i,
  input  logic req1_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt0_o = 1'b0;
    gnt1_o = 1'b0;
    ptr_d  = ptr_q;
    if (en_i) begin
      if (req0_i && req1_i) begin
        gnt0_o = (ptr_q == PORT0);
        gnt1_o = (ptr_q == PORT1);
      end else begin
        gnt0_o = req0_i;
        gnt1_o = req1_i;
      end
      // The pointer only moves when somebody is actually granted.
      if (gnt0_o) begin
        ptr_d = PORT1;
      end else if (gnt1_o) begin
        ptr_d = PORT0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= PORT0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: writes finish in the grant cycle, reads spend one
// RD_WAIT cycle returning the synchronous memory's data to the port that owns it.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p0_gnt,
  output logic              p1_gnt,
  output logic              p0_rvalid,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              arb_en;
  logic              win;

  rr_arbiter2 u_rr (
    .clk    (clk),
    .rst    (rst),
    .en_i   (arb_en),
    .req0_i (p0_req),
    .req1_i (p1_req),
    .gnt0_o (p0_gnt),
    .gnt1_o (p1_gnt)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rdata_d   = rdata_q;
    arb_en    = 1'b0;
    win       = PORT0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    p0_rvalid = 1'b0;
    p1_rvalid = 1'b0;
    rdata     = rdata_q;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        arb_en = 1'b1;
        if (p0_gnt || p1_gnt) begin
          win       = p1_gnt ? PORT1 : PORT0;
          mem_en    = 1'b1;
          mem_we    = (win == PORT1) ? p1_we    : p0_we;
          mem_addr  = (win == PORT1) ? p1_addr  : p0_addr;
          mem_wdata = (win == PORT1) ? p1_wdata : p0_wdata;
          if (!mem_we) begin
            state_d = RD_WAIT;
            owner_d = win;
          end
        end
      end
      RD_WAIT: begin
        // Memory data arrives this cycle; forward it now and keep a copy to hold.
        busy      = 1'b1;
        rdata     = mem_rdata;
        rdata_d   = mem_rdata;
        p0_rvalid = (owner_q == PORT0);
        p1_rvalid = (owner_q == PORT1);
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= PORT0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed accesses push hand-computed grant
// and read-return events; a negedge monitor pops and compares them.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        p0_req, p1_req, p0_we, p1_we;
  logic [4:0]  p0_addr, p1_addr;
  logic [31:0] p0_wdata, p1_wdata;
  logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [31:0] rdata;
  logic        mem_en, mem_we;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        busy;

  typedef struct {
    bit          isRv;
    bit          port;
    bit          we;
    logic [4:0]  addr;
    logic [31:0] data;
    int          gap;
  } exp_t;

  exp_t        expQ[$];
  int          checks = 0;
  int          errors = 0;
  int          cycle = 0;
  int          lastGntCycle = 0;
  logic [31:0] lastRdata = '0;
  logic [31:0] mem [32];

  dmem_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .p0_req    (p0_req),
    .p0_we     (p0_we),
    .p0_addr   (p0_addr),
    .p0_wdata  (p0_wdata),
    .p1_req    (p1_req),
    .p1_we     (p1_we),
    .p1_addr   (p1_addr),
    .p1_wdata  (p1_wdata),
    .p0_gnt    (p0_gnt),
    .p1_gnt    (p1_gnt),
    .p0_rvalid (p0_rvalid),
    .p1_rvalid (p1_rvalid),
    .rdata     (rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycle <= cycle + 1;

  // Synchronous memory; between reads it returns junk so a held rdata is visible.
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    mem_rdata = '0;
  end
  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
    else mem_rdata <= 32'hA5A5_0000 | cycle;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s got %h want %h (cycle %0d)", name, act, req, cycle);
    end
  endtask

  task automatic pushExp(input bit isRv, input bit port, input bit we,
                         input logic [4:0] addr, input logic [31:0] data, input int gap);
    exp_t e;
    e.isRv = isRv; e.port = port; e.we = we; e.addr = addr; e.data = data; e.gap = gap;
    expQ.push_back(e);
  endtask

  // Holds one request until its grant is observed, then withdraws it.
  task automatic applyStimulus(input bit port, input bit we, input logic [4:0] addr,
                               input logic [31:0] data);
    bit ok = 0;
    if (!port) begin
      p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = data;
    end else begin
      p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = data;
    end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (port ? p1_gnt : p0_gnt) begin
        ok = 1;
        break;
      end
    end
    if (!ok) checkOutput("gntTimeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    if (!port) p0_req = 1'b0;
    else p1_req = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      if (expQ.size() == 0) break;
    end
    checkOutput(name, expQ.size(), 32'd0);
    #1;
  endtask

  task automatic checkReset();
    checkOutput("rstGnt",    {p0_gnt, p1_gnt}, 32'd0);
    checkOutput("rstRvalid", {p0_rvalid, p1_rvalid}, 32'd0);
    checkOutput("rstMemEn",  {mem_en, mem_we}, 32'd0);
    checkOutput("rstBusy",   busy, 32'd0);
    checkOutput("rstRdata",  rdata, 32'd0);
  endtask

  task automatic applyReset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkReset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: every grant and every read return must match the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      lastRdata = '0;
    end else begin
      checkOutput("oneHotOut", ($countones({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid}) <= 1), 32'd1);
      if (p0_gnt || p1_gnt) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedGnt", {p0_gnt, p1_gnt}, 32'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("evKindGnt", 32'd0, e.isRv);
          checkOutput("gntPort", p1_gnt, e.port);
          checkOutput("gntMemEn", mem_en, 32'd1);
          checkOutput("gntMemWe", mem_we, e.we);
          checkOutput("gntMemAddr", mem_addr, e.addr);
          if (e.we) checkOutput("gntMemWdata", mem_wdata, e.data);
          if (e.gap > 0) checkOutput("gntGap", cycle - lastGntCycle, e.gap);
          lastGntCycle = cycle;
        end
      end else begin
        checkOutput("idleMem", {mem_en, mem_we}, 32'd0);
      end
      if (p0_rvalid || p1_rvalid) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedRvalid", {p0_rvalid, p1_rvalid}, 32'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("evKindRv", 32'd1, e.isRv);
          checkOutput("rvPort", p1_rvalid, e.port);
          checkOutput("rvData", rdata, e.data);
          checkOutput("rvBusy", busy, 32'd1);
          checkOutput("rvLatency", cycle - lastGntCycle, 32'd1);
          lastRdata = e.data;
        end
      end else begin
        checkOutput("rdataHold", rdata, lastRdata);
        checkOutput("busyIdle", busy, 32'd0);
      end
    end
  end

  initial begin
    rst = 1'b1;
    p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
    p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
    @(posedge clk);
    #1;
    applyReset();

    $display("[TB] p0 write then p1 read of address 5");
    pushExp(0, 0, 1, 5'd5, 32'hDEADBEEF, -1);
    applyStimulus(0, 1, 5'd5, 32'hDEADBEEF);
    waitDrain("drainWrite");
    pushExp(0, 1, 0, 5'd5, 32'h0, -1);
    pushExp(1, 1, 0, 5'd5, 32'hDEADBEEF, -1);
    applyStimulus(1, 0, 5'd5, 32'h0);
    waitDrain("drainRead");

    $display("[TB] simultaneous writes, pointer at p0");
    pushExp(0, 0, 1, 5'd1, 32'h11111111, -1);
    pushExp(0, 1, 1, 5'd2, 32'h22222222, 1);
    fork
      applyStimulus(0, 1, 5'd1, 32'h11111111);
      applyStimulus(1, 1, 5'd2, 32'h22222222);
    join
    waitDrain("drainDualWrite");

    $display("[TB] continuous reads from both ports after reset");
    applyReset();
    pushExp(0, 0, 0, 5'd1, 32'h0, -1);
    pushExp(1, 0, 0, 5'd1, 32'h11111111, -1);
    pushExp(0, 1, 0, 5'd2, 32'h0, 2);
    pushExp(1, 1, 0, 5'd2, 32'h22222222, -1);
    pushExp(0, 0, 0, 5'd2, 32'h0, 2);
    pushExp(1, 0, 0, 5'd2, 32'h22222222, -1);
    pushExp(0, 1, 0, 5'd1, 32'h0, 2);
    pushExp(1, 1, 0, 5'd1, 32'h11111111, -1);
    fork
      begin
        applyStimulus(0, 0, 5'd1, 32'h0);
        applyStimulus(0, 0, 5'd2, 32'h0);
      end
      begin
        applyStimulus(1, 0, 5'd2, 32'h0);
        applyStimulus(1, 0, 5'd1, 32'h0);
      end
    join
    waitDrain("drainAlternate");

    $display("[TB] writes requested during RD_WAIT");
    pushExp(0, 0, 0, 5'd1, 32'h0, -1);
    pushExp(1, 0, 0, 5'd1, 32'h11111111, -1);
    pushExp(0, 1, 1, 5'd7, 32'h77777777, 2);
    pushExp(0, 0, 1, 5'd6, 32'h66666666, 1);
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 5'd1;
    @(negedge clk);
    @(posedge clk);
    #1;
    p0_req = 1'b0;
    fork
      applyStimulus(1, 1, 5'd7, 32'h77777777);
      applyStimulus(0, 1, 5'd6, 32'h66666666);
      begin
        @(negedge clk);
        checkOutput("rdWaitMemEn", mem_en, 32'd0);
        checkOutput("rdWaitGnt", {p0_gnt, p1_gnt}, 32'd0);
        checkOutput("rdWaitBusy", busy, 32'd1);
      end
    join
    waitDrain("drainRdWaitWrites");

    $display("[TB] reset during RD_WAIT aborts the read");
    pushExp(0, 0, 0, 5'd1, 32'h0, -1);
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 5'd1;
    @(negedge clk);
    @(posedge clk);
    #1;
    p0_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checkReset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("abortQueue", expQ.size(), 32'd0);
    @(posedge clk);
    #1;
    pushExp(0, 0, 0, 5'd6, 32'h0, -1);
    pushExp(1, 0, 0, 5'd6, 32'h66666666, -1);
    pushExp(0, 1, 0, 5'd7, 32'h0, 2);
    pushExp(1, 1, 0, 5'd7, 32'h77777777, -1);
    fork
      applyStimulus(0, 0, 5'd6, 32'h0);
      applyStimulus(1, 0, 5'd7, 32'h0);
    join
    waitDrain("drainPtrReset");

    $display("[TB] p1 write withdrawn before grant");
    pushExp(0, 0, 0, 5'd2, 32'h0, -1);
    pushExp(1, 0, 0, 5'd2, 32'h22222222, -1);
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 5'd2;
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 5'd2; p1_wdata = 32'hBAD0BAD0;
    @(negedge clk);
    checkOutput("withdrawNoP1Gnt", p1_gnt, 32'd0);
    @(posedge clk);
    #1;
    p0_req = 1'b0;
    p1_req = 1'b0;
    waitDrain("drainWithdraw");
    pushExp(0, 0, 0, 5'd2, 32'h0, -1);
    pushExp(1, 0, 0, 5'd2, 32'h22222222, -1);
    applyStimulus(0, 0, 5'd2, 32'h0);
    waitDrain("drainReadBack");

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
    $fatal(1, "[TB] watchdog");
  end

endmodule
